// File: rtl/prog_clk_div.sv
// prog_clk_div: CH independent programmable clock dividers.
//
// Each channel counts enabled cycles up to its divisor D. At the terminal
// count it emits a one-cycle tick and toggles out, giving a tick period of D
// and an out period of 2D. A divisor loaded while the channel is running is
// held as pending and takes effect at the next terminal count, so the output
// is retuned without glitches.
//
// Ports:
//   clk     - system clock, rising edge
//   reset   - asynchronous, active-high clear of all channel state
//   en      - [CH]   per-channel count enable (low freezes the channel)
//   load    - [CH]   per-channel single-cycle divisor load strobe
//   div_in  - [CH*N] divisor for channel i in bits [i*N +: N]
//   oneshot - [CH]   mode captured with load: 1 = one-shot, 0 = continuous
//   out     - [CH]   registered square wave, toggles at each terminal count
//   tick    - [CH]   registered one-cycle pulse at each terminal count
//   active  - [CH]   channel running with a nonzero divisor
module prog_clk_div #(
  parameter int unsigned N  = 32,
  parameter int unsigned CH = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [CH-1:0]   en,
  input  logic [CH-1:0]   load,
  input  logic [CH*N-1:0] div_in,
  input  logic [CH-1:0]   oneshot,
  output logic [CH-1:0]   out,
  output logic [CH-1:0]   tick,
  output logic [CH-1:0]   active
);

  localparam logic [N-1:0] ONE = N'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [N-1:0] count;
    logic [N-1:0] div_q;
    logic [N-1:0] div_pend;
    logic         pend;
    logic         pend_mode;
    logic         mode_q;
    logic         act_q;
    logic         out_q;
    logic         tick_q;

    logic [N-1:0] din;
    logic         term;
    logic         halting;

    always_comb begin
      din     = div_in[i*N +: N];
      term    = act_q & en[i] & (div_q != '0) & (count == div_q - ONE);
      // Channel goes idle at this terminal edge: pending zero or one-shot.
      halting = term & (pend ? (div_pend == '0) : mode_q);
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count     <= '0;
        div_q     <= '0;
        div_pend  <= '0;
        pend      <= 1'b0;
        pend_mode <= 1'b0;
        mode_q    <= 1'b0;
        act_q     <= 1'b0;
        out_q     <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        tick_q <= 1'b0;
        if (term) begin
          count  <= '0;
          tick_q <= 1'b1;
          out_q  <= ~out_q;
          if (pend) begin
            div_q  <= div_pend;
            mode_q <= pend_mode;
            pend   <= 1'b0;
            act_q  <= (div_pend != '0);
          end else if (mode_q) begin
            act_q <= 1'b0;
          end
        end else if (act_q && en[i]) begin
          count <= count + ONE;
        end

        // Load is evaluated after the terminal update so that a load on a
        // terminal edge lands as the new pending value. If this edge idles
        // the channel, the load is applied directly instead so it is not
        // stranded as a pending value that would never be consumed.
        if (load[i]) begin
          if (!act_q || halting) begin
            div_q  <= din;
            mode_q <= oneshot[i];
            count  <= '0;
            pend   <= 1'b0;
            act_q  <= (din != '0);
          end else begin
            div_pend  <= din;
            pend_mode <= oneshot[i];
            pend      <= 1'b1;
          end
        end
      end
    end

    assign out[i]    = out_q;
    assign tick[i]   = tick_q;
    assign active[i] = act_q;
  end

endmodule

// File: tb/tb_prog_clk_div.sv
module tb_prog_clk_div;

  localparam int N  = 32;
  localparam int CH = 4;
  localparam bit H  = 1'b1;
  localparam bit L  = 1'b0;

  logic            clk = 1'b0;
  logic            reset;
  logic [CH-1:0]   en;
  logic [CH-1:0]   load;
  logic [CH*N-1:0] div_in;
  logic [CH-1:0]   oneshot;
  logic [CH-1:0]   out;
  logic [CH-1:0]   tick;
  logic [CH-1:0]   active;

  int n_chk  = 0;
  int n_fail = 0;

  prog_clk_div #(.N(N), .CH(CH)) dut (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .load    (load),
    .div_in  (div_in),
    .oneshot (oneshot),
    .out     (out),
    .tick    (tick),
    .active  (active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic        ld;
    logic [31:0] d;
    logic        t;
    logic        o;
    logic        a;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic e, logic l, logic [31:0] d,
                              logic t, logic o, logic a);
    vec_t v;
    v.en = e; v.ld = l; v.d = d; v.t = t; v.o = o; v.a = a;
    tbl.push_back(v);
  endfunction

  task automatic chk1(string name, logic act, logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk4(string name, logic [3:0] act, logic [3:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_div(int ch, logic [31:0] v);
    div_in[ch*N +: N] = v;
  endtask

  initial begin
    logic exp_o;
    int   cnt;

    reset   = 1'b1;
    en      = '0;
    load    = '0;
    oneshot = '0;
    div_in  = '0;
    #12;
    chk4("reset_tick", tick, 4'b0000);
    chk4("reset_out", out, 4'b0000);
    chk4("reset_active", active, 4'b0000);
    @(negedge clk);
    reset = 1'b0;

    // Ch0: D=4 continuous, retune to 6 at count=1, then 4, then load 0.
    // Columns: en, load, div, exp tick, exp out, exp active
    add(H, H, 32'd4, L, L, H);                 // E0
    for (int i = 0; i < 3; i++) add(H, L, 32'd0, L, L, H);
    add(H, L, 32'd0, H, H, H);                 // E0+4
    for (int i = 0; i < 3; i++) add(H, L, 32'd0, L, H, H);
    add(H, L, 32'd0, H, L, H);                 // E0+8
    add(H, L, 32'd0, L, L, H);                 // count 0->1
    add(H, H, 32'd6, L, L, H);                 // load at count=1
    add(H, L, 32'd0, L, L, H);
    add(H, L, 32'd0, H, H, H);                 // old period of 4 ends
    for (int i = 0; i < 5; i++) add(H, L, 32'd0, L, H, H);
    add(H, L, 32'd0, H, L, H);                 // first period of 6
    add(H, H, 32'd4, L, L, H);                 // pending 4
    for (int i = 0; i < 4; i++) add(H, L, 32'd0, L, L, H);
    add(H, L, 32'd0, H, H, H);                 // second period of 6
    add(H, H, 32'd0, L, H, H);                 // pending 0
    add(H, L, 32'd0, L, H, H);
    add(H, L, 32'd0, L, H, H);
    add(H, L, 32'd0, H, L, L);                 // last tick, halts
    for (int i = 0; i < 4; i++) add(H, L, 32'd0, L, L, L);
    add(H, H, 32'd0, L, L, L);                 // load 0 to idle channel
    for (int i = 0; i < 3; i++) add(H, L, 32'd0, L, L, L);

    for (int i = 0; i < tbl.size(); i++) begin
      en[0]   = tbl[i].en;
      load[0] = tbl[i].ld;
      set_div(0, tbl[i].d);
      step();
      chk1($sformatf("tbl%0d_tick", i), tick[0], tbl[i].t);
      chk1($sformatf("tbl%0d_out", i), out[0], tbl[i].o);
      chk1($sformatf("tbl%0d_active", i), active[0], tbl[i].a);
    end
    load[0] = 1'b0;
    en[0]   = 1'b0;

    // Ch1: D=1 ticks every cycle, out toggles every cycle.
    en[1] = 1'b1;
    set_div(1, 32'd1);
    load[1] = 1'b1;
    step();
    load[1] = 1'b0;
    chk1("ch1_load_active", active[1], 1'b1);
    chk1("ch1_load_tick", tick[1], 1'b0);
    exp_o = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_o = ~exp_o;
      chk1($sformatf("ch1_tick%0d", i), tick[1], 1'b1);
      chk1($sformatf("ch1_out%0d", i), out[1], exp_o);
    end
    en[1] = 1'b0;

    // Ch2: D=3 with enable dropped for 5 cycles mid-count.
    en[2] = 1'b1;
    set_div(2, 32'd3);
    load[2] = 1'b1;
    step();
    load[2] = 1'b0;
    chk1("ch2_active", active[2], 1'b1);
    step();
    step();
    chk1("ch2_pre_tick", tick[2], 1'b0);
    en[2] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk1($sformatf("ch2_frz_tick%0d", i), tick[2], 1'b0);
      chk1($sformatf("ch2_frz_out%0d", i), out[2], 1'b0);
    end
    en[2] = 1'b1;
    step();
    chk1("ch2_resume_tick", tick[2], 1'b1);
    chk1("ch2_resume_out", out[2], 1'b1);
    step();
    chk1("ch2_c1_tick", tick[2], 1'b0);
    step();
    chk1("ch2_c2_tick", tick[2], 1'b0);
    step();
    chk1("ch2_next_tick", tick[2], 1'b1);
    chk1("ch2_next_out", out[2], 1'b0);

    // Ch3: one-shot D=5.
    en[3] = 1'b1;
    set_div(3, 32'd5);
    oneshot[3] = 1'b1;
    load[3] = 1'b1;
    step();
    load[3] = 1'b0;
    oneshot[3] = 1'b0;
    chk1("ch3_active", active[3], 1'b1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk1($sformatf("ch3_wait_tick%0d", i), tick[3], 1'b0);
    end
    step();
    chk1("ch3_tick", tick[3], 1'b1);
    chk1("ch3_out", out[3], 1'b1);
    chk1("ch3_done_active", active[3], 1'b0);
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      cnt += int'(tick[3]);
    end
    chk32("ch3_no_more_ticks", cnt, 0);
    chk1("ch3_idle_active", active[3], 1'b0);
    chk1("ch3_idle_out", out[3], 1'b1);
    set_div(3, 32'd2);
    oneshot[3] = 1'b1;
    load[3] = 1'b1;
    step();
    load[3] = 1'b0;
    oneshot[3] = 1'b0;
    step();
    chk1("ch3_rl_wait", tick[3], 1'b0);
    step();
    chk1("ch3_rl_tick", tick[3], 1'b1);
    chk1("ch3_rl_out", out[3], 1'b0);
    chk1("ch3_rl_active", active[3], 1'b0);

    // Asynchronous reset mid-count with a pending load outstanding.
    en = 4'b1111;
    set_div(0, 32'd4);
    set_div(2, 32'd7);
    load = 4'b0101;
    step();
    load = '0;
    step();
    step();
    chk1("pre_reset_ch1_tick", tick[1], 1'b1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk4("async_rst_tick", tick, 4'b0000);
    chk4("async_rst_out", out, 4'b0000);
    chk4("async_rst_active", active, 4'b0000);
    @(posedge clk);
    #3;
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (tick != '0 || active != '0) cnt++;
    end
    chk32("post_rst_idle_cycles", cnt, 0);

    // Load on the first edge after release, then load + terminal together.
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #3;
    reset = 1'b0;
    set_div(0, 32'd2);
    load = 4'b0001;
    step();
    load = '0;
    chk4("rel_load_active", active, 4'b0001);
    step();
    chk1("rel_c1_tick", tick[0], 1'b0);
    step();
    chk1("rel_t1_tick", tick[0], 1'b1);
    chk1("rel_t1_out", out[0], 1'b1);
    step();
    chk1("rel_c2_tick", tick[0], 1'b0);
    set_div(0, 32'd3);
    load[0] = 1'b1;
    step();
    load[0] = 1'b0;
    chk1("same_edge_tick", tick[0], 1'b1);
    chk1("same_edge_out", out[0], 1'b0);
    step();
    chk1("same_edge_c1", tick[0], 1'b0);
    step();
    chk1("old_div_tick", tick[0], 1'b1);
    chk1("old_div_out", out[0], 1'b1);
    step();
    chk1("new_div_c1", tick[0], 1'b0);
    step();
    chk1("new_div_c2", tick[0], 1'b0);
    step();
    chk1("new_div_tick", tick[0], 1'b1);
    chk1("new_div_out", out[0], 1'b0);
    chk1("new_div_active", active[0], 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 Parameter N, default 32: width of each channel's divisor and counter.
REQ-002 Parameter CH, default 4: number of independent divider channels.
REQ-003 clk  input  1  system clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-005 en  input  CH  per-channel count enable; low freezes that channel.
REQ-006 load  input  CH  per-channel single-cycle divisor-load strobe.
REQ-007 div_in  input  CH*N  divisor for channel i in bits [i*N +: N]; sampled only when load[i]=1.
REQ-008 oneshot  input  CH  per-channel mode, sampled with load[i]: 1 = one-shot, 0 = continuous.
REQ-009 out  output  CH  registered square wave, toggles at each terminal count.
REQ-010 tick  output  CH  registered one-cycle pulse at each terminal count.
REQ-011 active  output  CH  channel running with a nonzero divisor.

Function
REQ-012 Channels shall be fully independent; per-channel state: count[N], div_q[N], div_pend[N], pend, mode_q, active, out, tick.
REQ-013 Terminal count: active=1, en=1, div_q!=0, count==div_q-1 (N-bit compare, no overflow: div_q=1 means terminal every enabled cycle).
REQ-014 At a terminal edge: count<=0, tick<=1, out<=~out; otherwise, if active and en, count<=count+1 and tick<=0.
REQ-015 tick shall be 0 in every cycle not directly following a terminal edge; tick period = D cycles and out period = 2D cycles for divisor D with en held high.
REQ-016 en=0: count, out, active and pending state hold; tick<=0; load is still accepted.
REQ-017 Load to an idle channel (active=0): div_q<=div_in slice, mode_q<=oneshot, count<=0, pend<=0, active<=(div_in!=0); out holds.
REQ-018 Load to an active channel: div_pend<=div_in slice, pend<=1; mode is captured with the divisor; div_q and count are unaffected until the next terminal edge (glitch-free retune).
REQ-019 Repeated loads before the terminal edge: the last one wins.
REQ-020 Terminal edge with pend=1: div_q<=div_pend, pend<=0, and active<=(div_pend!=0); loading 0 therefore halts the channel after the current period completes.
REQ-021 Load and terminal on the same edge: the terminal uses the current pending value, if any, then the new div_in is stored as pending; no load is lost.
REQ-022 One-shot (mode_q=1, no pend): the first terminal edge produces tick and out toggle, then active<=0; count holds 0; restart only by a new load.
REQ-023 First tick after a load to an idle channel with divisor D and en high: tick is high in the cycle after edge E0+D, where E0 is the load edge.
REQ-024 Loading 0 to an idle channel shall leave active=0 and produce no tick.

Reset
REQ-025 reset=1 shall asynchronously force, for all channels, count=0, div_q=0, div_pend=0, pend=0, mode_q=0, active=0, out=0, tick=0, regardless of clk.
REQ-026 Mid-operation reset shall discard all pending loads; after release, channels stay idle until loaded.
REQ-027 A load coincident with the first edge after reset deassertion shall be accepted normally.

Verification
REQ-028 Ch0: load D=4, continuous, en=1 -> tick every 4 cycles, first tick in the cycle after E0+4; out toggles with each tick (period 8); active=1.
REQ-029 Ch1: D=1 -> tick held high continuously; out toggles every cycle. Ch2: D=3 with en low for 5 cycles mid-count -> count and out frozen, tick=0, then resume with no lost or extra count.
REQ-030 Ch0 running D=4: load 6 at count=1 -> current period still ends at 4 cycles, subsequent periods are 6; load 0 instead -> exactly one more tick, then active=0.
REQ-031 Ch3 one-shot D=5 -> exactly one tick 5 cycles after load, out toggles once, active drops; no further ticks over 50 cycles until reloaded.
REQ-032 Reset asserted asynchronously mid-count, between clock edges, on all 4 channels -> all outputs 0 immediately; after release, no ticks until load; load plus terminal on the same edge -> both honoured.
